// File: rtl/arbitro_de_acesso.sv
// Two-user priority arbiter: the winner holds Grant for TEMPO cycles, then a queued loser is served with no idle gap.
// Latency: one cycle from request to Grant; requests are ignored while serving, so a busy arbiter simply does not sample them.
module arbitro_de_acesso #(
    parameter int TEMPO = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] User0,
    input  logic [2:0] User1,
    output logic [1:0] Grant,
    output logic [2:0] CodigoAtivo,
    output logic [2:0] CodigoPendente,
    output logic       Ocupado,
    output logic       Erro
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam logic [3:0] RELOAD = 4'(TEMPO - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       pend;
    logic       pend_nxt;
    logic [1:0] grant_nxt;
    logic [2:0] ativo_nxt;
    logic [2:0] pend_cod_nxt;
    logic       erro_nxt;

    logic [2:0] rank0;
    logic [2:0] rank1;
    logic       inv0;
    logic       inv1;
    logic       win1;
    logic [2:0] loser_code;
    logic [2:0] loser_rank;

    // Higher rank wins; rank 0 covers both "no request" and invalid codes.
    function automatic logic [2:0] rank_of(input logic [2:0] code);
        case (code)
            3'b101:  rank_of = 3'd4;
            3'b011:  rank_of = 3'd3;
            3'b001:  rank_of = 3'd2;
            3'b110:  rank_of = 3'd1;
            default: rank_of = 3'd0;
        endcase
    endfunction

    function automatic logic is_invalid(input logic [2:0] code);
        is_invalid = (code == 3'b010) || (code == 3'b100) || (code == 3'b111);
    endfunction

    always_comb begin
        rank0      = rank_of(User0);
        rank1      = rank_of(User1);
        inv0       = is_invalid(User0);
        inv1       = is_invalid(User1);
        win1       = (rank1 > rank0);
        loser_code = win1 ? User0 : User1;
        loser_rank = win1 ? rank0 : rank1;
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pend_nxt     = pend;
        grant_nxt    = Grant;
        ativo_nxt    = CodigoAtivo;
        pend_cod_nxt = CodigoPendente;
        erro_nxt     = 1'b0;

        case (state)
            IDLE: begin
                erro_nxt     = inv0 | inv1;
                cnt_nxt      = 4'd0;
                pend_nxt     = 1'b0;
                grant_nxt    = 2'b00;
                ativo_nxt    = 3'b000;
                pend_cod_nxt = 3'b000;
                if ((rank0 != 3'd0) || (rank1 != 3'd0)) begin
                    state_nxt = SERVE;
                    cnt_nxt   = RELOAD;
                    grant_nxt = win1 ? 2'b10 : 2'b01;
                    ativo_nxt = win1 ? User1 : User0;
                    if (loser_rank != 3'd0) begin
                        pend_nxt     = 1'b1;
                        pend_cod_nxt = loser_code;
                    end
                end
            end

            SERVE: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else if (pend) begin
                    // Hand over to the queued user even if it has since withdrawn.
                    grant_nxt    = {Grant[0], Grant[1]};
                    ativo_nxt    = CodigoPendente;
                    pend_cod_nxt = 3'b000;
                    pend_nxt     = 1'b0;
                    cnt_nxt      = RELOAD;
                end else begin
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                    ativo_nxt = 3'b000;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            pend           <= 1'b0;
            Grant          <= 2'b00;
            CodigoAtivo    <= 3'b000;
            CodigoPendente <= 3'b000;
            Erro           <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            pend           <= pend_nxt;
            Grant          <= grant_nxt;
            CodigoAtivo    <= ativo_nxt;
            CodigoPendente <= pend_cod_nxt;
            Erro           <= erro_nxt;
        end
    end

    assign Ocupado = (state == SERVE);

endmodule

// File: tb/tb_arbitro_de_acesso.sv
// Bench for arbitro_de_acesso: two instances (TEMPO=4 and TEMPO=1) share stimulus and are checked against a schedule-based model.
module tb_arbitro_de_acesso;

    logic       Clock;
    logic       Reset;
    logic [2:0] User0;
    logic [2:0] User1;

    logic [1:0] g0, g1;
    logic [2:0] ca0, cp0, ca1, cp1;
    logic       oc0, er0, oc1, er1;

    arbitro_de_acesso #(.TEMPO(4)) dut0 (
        .Clock(Clock), .Reset(Reset), .User0(User0), .User1(User1),
        .Grant(g0), .CodigoAtivo(ca0), .CodigoPendente(cp0), .Ocupado(oc0), .Erro(er0)
    );

    arbitro_de_acesso #(.TEMPO(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .User0(User0), .User1(User1),
        .Grant(g1), .CodigoAtivo(ca1), .CodigoPendente(cp1), .Ocupado(oc1), .Erro(er1)
    );

    typedef struct packed {
        logic [1:0] g;
        logic [2:0] ca;
        logic [2:0] cp;
        logic       oc;
        logic       er;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    bit   run   = 0;

    // Model: on acceptance, the whole grant sequence is expanded into a per-cycle schedule.
    exp_t cur   [2];
    exp_t sched [2][32];
    int   len   [2];
    int   pos   [2];
    int   tp    [2];

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic int prio(input logic [2:0] c);
        case (c)
            3'b101:  return 4;
            3'b011:  return 3;
            3'b001:  return 2;
            3'b110:  return 1;
            default: return 0;
        endcase
    endfunction

    function automatic bit bad_code(input logic [2:0] c);
        return (c == 3'b010) || (c == 3'b100) || (c == 3'b111);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input logic [2:0] u0, input logic [2:0] u1);
        int   p0, p1, lp;
        bit   w1;
        logic [2:0] wc, lc;
        exp_t e;
        if (pos[k] < len[k]) begin
            cur[k] = sched[k][pos[k]];
            pos[k]++;
        end else if (cur[k].oc) begin
            cur[k] = '0;
        end else begin
            p0 = prio(u0);
            p1 = prio(u1);
            len[k] = 0;
            pos[k] = 0;
            if (p0 > 0 || p1 > 0) begin
                w1 = (p1 > p0);
                wc = w1 ? u1 : u0;
                lc = w1 ? u0 : u1;
                lp = w1 ? p0 : p1;
                for (int i = 0; i < tp[k]; i++) begin
                    e.g  = w1 ? 2'b10 : 2'b01;
                    e.ca = wc;
                    e.cp = (lp > 0) ? lc : 3'b000;
                    e.oc = 1'b1;
                    e.er = 1'b0;
                    sched[k][len[k]] = e;
                    len[k]++;
                end
                if (lp > 0) begin
                    for (int i = 0; i < tp[k]; i++) begin
                        e.g  = w1 ? 2'b01 : 2'b10;
                        e.ca = lc;
                        e.cp = 3'b000;
                        e.oc = 1'b1;
                        e.er = 1'b0;
                        sched[k][len[k]] = e;
                        len[k]++;
                    end
                end
                cur[k]    = sched[k][0];
                pos[k]    = 1;
                cur[k].er = bad_code(u0) | bad_code(u1);
            end else begin
                cur[k]    = '0;
                cur[k].er = bad_code(u0) | bad_code(u1);
            end
        end
    endtask

    always @(posedge Clock or posedge Reset) begin
        for (int k = 0; k < 2; k++) begin
            if (Reset) begin
                cur[k] = '0;
                len[k] = 0;
                pos[k] = 0;
            end else begin
                model_step(k, User0, User1);
            end
        end
    end

    task automatic check_inst(input int k, input logic [1:0] g, input logic [2:0] ca,
                              input logic [2:0] cp, input logic oc, input logic er);
        chk($sformatf("i%0d_grant", k), 8'(g), 8'(cur[k].g));
        chk($sformatf("i%0d_ativo", k), 8'(ca), 8'(cur[k].ca));
        chk($sformatf("i%0d_pendente", k), 8'(cp), 8'(cur[k].cp));
        chk($sformatf("i%0d_ocupado", k), 8'(oc), 8'(cur[k].oc));
        chk($sformatf("i%0d_erro", k), 8'(er), 8'(cur[k].er));
        chk($sformatf("i%0d_grant_not_11", k), 8'(g == 2'b11), 8'd0);
    endtask

    always @(negedge Clock) begin
        if (run && !Reset) begin
            check_inst(0, g0, ca0, cp0, oc0, er0);
            check_inst(1, g1, ca1, cp1, oc1, er1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    initial begin
        tp[0] = 4;
        tp[1] = 1;
        for (int k = 0; k < 2; k++) begin
            cur[k] = '0;
            len[k] = 0;
            pos[k] = 0;
        end
        Reset = 1'b1;
        User0 = 3'b000;
        User1 = 3'b000;
        @(negedge Clock);
        chk("rst_grant", 8'(g0), 8'h0);
        chk("rst_ativo", 8'(ca0), 8'h0);
        chk("rst_pendente", 8'(cp0), 8'h0);
        chk("rst_ocupado", 8'(oc0), 8'h0);
        chk("rst_erro", 8'(er0), 8'h0);
        Reset = 1'b0;
        run   = 1'b1;
        cyc(2);

        // Scenario 1: 101 on interface 1 beats 011 on interface 0
        User0 = 3'b011; User1 = 3'b101;
        cyc(1);
        User0 = 3'b000; User1 = 3'b000;
        chk("s1_c1_grant", 8'(g0), 8'h2);
        chk("s1_c1_ativo", 8'(ca0), 8'h5);
        chk("s1_c1_pend", 8'(cp0), 8'h3);
        chk("s1_c1_ocup", 8'(oc0), 8'h1);
        cyc(3);
        chk("s1_c4_grant", 8'(g0), 8'h2);
        cyc(1);
        chk("s1_c5_grant", 8'(g0), 8'h1);
        chk("s1_c5_ativo", 8'(ca0), 8'h3);
        chk("s1_c5_pend", 8'(cp0), 8'h0);
        cyc(3);
        chk("s1_c8_grant", 8'(g0), 8'h1);
        cyc(1);
        chk("s1_c9_grant", 8'(g0), 8'h0);
        chk("s1_c9_ocup", 8'(oc0), 8'h0);
        chk("s1_c9_ativo", 8'(ca0), 8'h0);
        cyc(3);

        // Scenario 2: equal codes, interface 0 first; invalid code during SERVE is ignored
        User0 = 3'b110; User1 = 3'b110;
        cyc(1);
        User0 = 3'b000; User1 = 3'b000;
        chk("s2_c1_grant", 8'(g0), 8'h1);
        chk("s2_c1_pend", 8'(cp0), 8'h6);
        cyc(1);
        User0 = 3'b100;
        cyc(1);
        User0 = 3'b000;
        chk("s2_c3_erro0", 8'(er0), 8'h0);
        chk("s2_c3_erro1", 8'(er1), 8'h0);
        cyc(2);
        chk("s2_c5_grant", 8'(g0), 8'h2);
        chk("s2_c5_ativo", 8'(ca0), 8'h6);
        cyc(4);
        chk("s2_c9_grant", 8'(g0), 8'h0);
        cyc(2);

        // Scenario 3: one invalid, one valid
        User0 = 3'b111; User1 = 3'b001;
        cyc(1);
        User0 = 3'b000; User1 = 3'b000;
        chk("s3_c1_erro", 8'(er0), 8'h1);
        chk("s3_c1_grant", 8'(g0), 8'h2);
        chk("s3_c1_pend", 8'(cp0), 8'h0);
        chk("s3_c1_erro_t1", 8'(er1), 8'h1);
        cyc(1);
        chk("s3_c2_erro", 8'(er0), 8'h0);
        cyc(3);
        chk("s3_c5_grant", 8'(g0), 8'h0);
        cyc(2);

        // Only invalid codes: Erro without a grant
        User0 = 3'b010; User1 = 3'b100;
        cyc(1);
        User0 = 3'b000; User1 = 3'b000;
        chk("inv_c1_erro", 8'(er0), 8'h1);
        chk("inv_c1_grant", 8'(g0), 8'h0);
        cyc(1);
        chk("inv_c2_erro", 8'(er0), 8'h0);
        cyc(1);

        // Scenario 4: no preemption, one IDLE cycle before the newcomer
        User0 = 3'b001; User1 = 3'b000;
        cyc(1);
        chk("s4_c1_grant", 8'(g0), 8'h1);
        User0 = 3'b000; User1 = 3'b101;
        cyc(3);
        chk("s4_c4_grant", 8'(g0), 8'h1);
        cyc(1);
        chk("s4_c5_grant", 8'(g0), 8'h0);
        cyc(1);
        chk("s4_c6_grant", 8'(g0), 8'h2);
        chk("s4_c6_ativo", 8'(ca0), 8'h5);
        User1 = 3'b000;
        cyc(7);

        // Scenario 5: Reset mid-SERVE drops both active and pending users
        User0 = 3'b011; User1 = 3'b101;
        cyc(1);
        User0 = 3'b000; User1 = 3'b000;
        cyc(1);
        chk("s5_c2_grant", 8'(g0), 8'h2);
        chk("s5_c2_pend", 8'(cp0), 8'h3);
        #2 Reset = 1'b1;
        #1;
        chk("s5_rst_grant", 8'(g0), 8'h0);
        chk("s5_rst_ativo", 8'(ca0), 8'h0);
        chk("s5_rst_pend", 8'(cp0), 8'h0);
        chk("s5_rst_ocup", 8'(oc0), 8'h0);
        chk("s5_rst_erro", 8'(er0), 8'h0);
        @(negedge Clock);
        #2 Reset = 1'b0;
        cyc(8);
        chk("s5_after_grant", 8'(g0), 8'h0);
        chk("s5_after_pend", 8'(cp0), 8'h0);
        cyc(1);

        // Scenario 6: TEMPO=1 back-to-back pair
        User0 = 3'b101; User1 = 3'b001;
        cyc(1);
        User0 = 3'b000; User1 = 3'b000;
        chk("s6_c1_grant", 8'(g1), 8'h1);
        chk("s6_c1_ativo", 8'(ca1), 8'h5);
        chk("s6_c1_pend", 8'(cp1), 8'h1);
        cyc(1);
        chk("s6_c2_grant", 8'(g1), 8'h2);
        chk("s6_c2_ativo", 8'(ca1), 8'h1);
        cyc(1);
        chk("s6_c3_grant", 8'(g1), 8'h0);
        cyc(10);

        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
